// File: rtl/fas_frame_sched_if.sv
// Signal bundle between the FAS frame scheduler, the FIR stream, the ping-pong
// sample RAM write port and the FFT engine handshake.
interface fas_frame_sched_if #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int CW = 8
) ();
    logic          fir_valid;
    logic [DW-1:0] fir_d;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          fft_ready;
    logic          fft_start;
    logic          fft_bank;
    logic          fft_done;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] drop_cnt;
    logic          overflow;
    logic          proto_err;
    logic          all_done;

    modport slave (
        input  fir_valid, fir_d, fft_ready, fft_done,
        output wr_en, wr_bank, wr_addr, wr_data, fft_start, fft_bank,
               frame_cnt, drop_cnt, overflow, proto_err, all_done
    );

    modport master (
        output fir_valid, fir_d, fft_ready, fft_done,
        input  wr_en, wr_bank, wr_addr, wr_data, fft_start, fft_bank,
               frame_cnt, drop_cnt, overflow, proto_err, all_done
    );
endinterface

// File: rtl/fas_frame_sched.sv
// Packs FIR samples into ping-pong RAM banks and launches the FFT engine on each
// full bank, one frame in flight, until NUM_FRAMES frames have completed.
module fas_frame_sched #(
    parameter int DW         = 16,
    parameter int FRAME_LEN  = 16,
    parameter int AW         = 4,
    parameter int NUM_FRAMES = 64,
    parameter int CW         = 8
) (
    input  logic               clk,
    input  logic               rst,
    fas_frame_sched_if.slave   bus
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_st_t;
    typedef enum logic {IDLE, WAIT_DONE} launch_st_t;

    bank_st_t      bank_st [2];
    launch_st_t    state;
    logic          wb;
    logic          rb;
    logic [AW-1:0] fill;
    logic [DW-1:0] sample;

    logic wb_open;
    logic take;
    logic drop;
    logic launch;
    logic finish;
    logic stray_done;

    // All decisions look at pre-edge state, so a bank freed this cycle is not
    // writable until the next one (no same-cycle bypass).
    assign sample     = bus.fir_d;
    assign wb_open    = (bank_st[wb] == EMPTY) || (bank_st[wb] == FILLING);
    assign take       = bus.fir_valid && !bus.all_done && wb_open;
    assign drop       = bus.fir_valid && !bus.all_done && !wb_open;
    assign launch     = (state == IDLE) && (bank_st[rb] == FULL) &&
                        bus.fft_ready && !bus.all_done;
    // A done that coincides with our own start pulse belongs to an older frame.
    assign finish     = (state == WAIT_DONE) && bus.fft_done && !bus.fft_start;
    assign stray_done = bus.fft_done && !finish;

    // NOTE: every register here, outputs included, is updated with <= so all
    // branches see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st[0]    <= EMPTY;
            bank_st[1]    <= EMPTY;
            state         <= IDLE;
            wb            <= 1'b0;
            rb            <= 1'b0;
            fill          <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_bank   <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.fft_start <= 1'b0;
            bus.fft_bank  <= 1'b0;
            bus.frame_cnt <= '0;
            bus.drop_cnt  <= '0;
            bus.overflow  <= 1'b0;
            bus.proto_err <= 1'b0;
            bus.all_done  <= 1'b0;
        end else begin
            bus.wr_en     <= take;
            bus.fft_start <= launch;

            if (take) begin
                bus.wr_bank <= wb;
                bus.wr_addr <= fill;
                bus.wr_data <= sample;
                if (fill == AW'(FRAME_LEN - 1)) begin
                    bank_st[wb] <= FULL;
                    fill        <= '0;
                    wb          <= ~wb;
                end else begin
                    bank_st[wb] <= FILLING;
                    fill        <= fill + AW'(1);
                end
            end

            if (drop) begin
                bus.overflow <= 1'b1;
                if (bus.drop_cnt != {CW{1'b1}})
                    bus.drop_cnt <= bus.drop_cnt + CW'(1);
            end

            // take targets a non-BUSY/FULL bank, launch a FULL one and finish a
            // BUSY one, so the bank_st writes below never collide.
            if (launch) begin
                bus.fft_bank <= rb;
                bank_st[rb]  <= BUSY;
                state        <= WAIT_DONE;
            end

            if (finish) begin
                bank_st[rb]   <= EMPTY;
                rb            <= ~rb;
                bus.frame_cnt <= bus.frame_cnt + CW'(1);
                if (bus.frame_cnt == CW'(NUM_FRAMES - 1))
                    bus.all_done <= 1'b1;
                state <= IDLE;
            end

            if (stray_done)
                bus.proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fas_frame_sched.sv
// Directed bench for fas_frame_sched: a vector table for the first frame plus
// hand-written sequences for overflow, completion, protocol errors and reset.
module tb_fas_frame_sched;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int FL = 16;
    localparam int NF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fas_frame_sched_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    fas_frame_sched #(
        .DW(DW), .FRAME_LEN(FL), .AW(AW), .NUM_FRAMES(NF), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          rdy;
        logic          done;
        logic          e_wr;
        logic          e_bank;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_start;
        logic          e_fbank;
        logic [CW-1:0] e_frames;
        logic          e_ovf;
        logic          e_perr;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fir_valid = 1'b0;
        bus.fir_d     = '0;
        bus.fft_ready = 1'b0;
        bus.fft_done  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check(tag, {bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.fft_start,
                    bus.fft_bank, bus.frame_cnt, bus.drop_cnt, bus.overflow,
                    bus.proto_err, bus.all_done}, 64'd0);
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.fir_valid = 1'b1;
        bus.fir_d     = d;
        tick();
        bus.fir_valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic bank, input logic [AW-1:0] addr);
        check({tag, " wr_en"}, bus.wr_en, 1'b1);
        check({tag, " wr_bank"}, bus.wr_bank, bank);
        check({tag, " wr_addr"}, bus.wr_addr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int n_wr;
        int n_start;
        int n_done;
        int n_extra;
        logic done_now;

        // First frame: 16 samples into bank 0, launch one cycle after addr 15.
        for (int k = 0; k < FL; k++)
            tbl[k] = '{1'b1, DW'(16'hA000 + k), 1'b1, 1'b0,
                       1'b1, 1'b0, AW'(k), DW'(16'hA000 + k),
                       1'b0, 1'b0, CW'(0), 1'b0, 1'b0};
        tbl[16] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, CW'(0), 1'b0, 1'b0};
        tbl[17] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, CW'(0), 1'b0, 1'b0};

        idle_inputs();
        #3;
        check_zero("reset held");
        do_reset();
        check_zero("after reset");

        for (int i = 0; i < 18; i++) begin
            bus.fir_valid = tbl[i].v;
            bus.fir_d     = tbl[i].d;
            bus.fft_ready = tbl[i].rdy;
            bus.fft_done  = tbl[i].done;
            tick();
            check($sformatf("vec%0d wr_en", i), bus.wr_en, tbl[i].e_wr);
            if (tbl[i].e_wr) begin
                check($sformatf("vec%0d wr_bank", i), bus.wr_bank, tbl[i].e_bank);
                check($sformatf("vec%0d wr_addr", i), bus.wr_addr, tbl[i].e_addr);
                check($sformatf("vec%0d wr_data", i), bus.wr_data, tbl[i].e_data);
            end
            check($sformatf("vec%0d fft_start", i), bus.fft_start, tbl[i].e_start);
            check($sformatf("vec%0d fft_bank", i), bus.fft_bank, tbl[i].e_fbank);
            check($sformatf("vec%0d frame_cnt", i), bus.frame_cnt, tbl[i].e_frames);
            check($sformatf("vec%0d overflow", i), bus.overflow, tbl[i].e_ovf);
            check($sformatf("vec%0d proto_err", i), bus.proto_err, tbl[i].e_perr);
        end
        bus.fir_valid = 1'b0;

        // fft_done on the 20th edge after the start pulse
        repeat (18) tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        check("t1 frame_cnt", bus.frame_cnt, 8'd1);
        check("t1 all_done", bus.all_done, 1'b0);
        check("t1 proto_err", bus.proto_err, 1'b0);

        // bank 1 then the freed bank 0 accept a full frame each
        bus.fft_ready = 1'b0;
        for (int k = 0; k < 2 * FL; k++) begin
            send(DW'(k));
            check_wr($sformatf("t1 reuse%0d", k), (k < FL) ? 1'b1 : 1'b0, AW'(k % FL));
        end
        check("t1 drop_cnt", bus.drop_cnt, 8'd0);
        check("t1 overflow", bus.overflow, 1'b0);

        // Overflow with both banks full, then launches in fill order.
        do_reset();
        n_start = 0;
        for (int k = 0; k < 2 * FL; k++) begin
            send(DW'(k));
            check($sformatf("t2 wr_en%0d", k), bus.wr_en, 1'b1);
            if (bus.fft_start) n_start++;
        end
        send(16'hDEAD);
        check("t2 drop wr_en", bus.wr_en, 1'b0);
        check("t2 drop_cnt", bus.drop_cnt, 8'd1);
        check("t2 overflow", bus.overflow, 1'b1);
        check("t2 no early start", n_start, 0);
        bus.fft_ready = 1'b1;
        tick();
        check("t2 start0", bus.fft_start, 1'b1);
        check("t2 bank0", bus.fft_bank, 1'b0);
        tick();
        check("t2 start pulse", bus.fft_start, 1'b0);
        repeat (3) tick();
        bus.fft_done  = 1'b1;
        bus.fir_valid = 1'b1;
        bus.fir_d     = 16'hBEEF;
        tick();
        bus.fft_done = 1'b0;
        check("t2 frame_cnt", bus.frame_cnt, 8'd1);
        check("t2 no bypass wr_en", bus.wr_en, 1'b0);
        check("t2 drop_cnt2", bus.drop_cnt, 8'd2);
        check("t2 start hold", bus.fft_start, 1'b0);
        bus.fir_d = 16'hCAFE;
        tick();
        bus.fir_valid = 1'b0;
        check("t2 start1", bus.fft_start, 1'b1);
        check("t2 bank1", bus.fft_bank, 1'b1);
        check_wr("t2 after free", 1'b0, 4'd0);
        check("t2 overflow sticky", bus.overflow, 1'b1);

        // fft_done before any start
        do_reset();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        check("t4 proto_err", bus.proto_err, 1'b1);
        check("t4 frame_cnt", bus.frame_cnt, 8'd0);
        check("t4 start", bus.fft_start, 1'b0);
        bus.fft_ready = 1'b1;
        send(16'h1234);
        check_wr("t4 first", 1'b0, 4'd0);
        check("t4 wr_data", bus.wr_data, 16'h1234);

        // Last sample of bank 1 coincides with fft_done for bank 0.
        do_reset();
        bus.fft_ready = 1'b1;
        for (int k = 0; k < FL; k++) send(DW'(k));
        for (int k = 0; k < FL; k++) begin
            bus.fir_valid = 1'b1;
            bus.fir_d     = DW'(16'h0B00 + k);
            bus.fft_done  = (k == FL - 1);
            tick();
            check_wr($sformatf("t5 b1s%0d", k), 1'b1, AW'(k));
            if (k == 0) begin
                check("t5 start0", bus.fft_start, 1'b1);
                check("t5 bank0", bus.fft_bank, 1'b0);
            end
        end
        bus.fft_done = 1'b0;
        check("t5 frame_cnt", bus.frame_cnt, 8'd1);
        check("t5 start quiet", bus.fft_start, 1'b0);
        bus.fir_d = 16'h5555;
        tick();
        bus.fir_valid = 1'b0;
        check("t5 start1", bus.fft_start, 1'b1);
        check("t5 bank1", bus.fft_bank, 1'b1);
        check_wr("t5 bank0 free", 1'b0, 4'd0);
        // done in the same cycle as fft_start is stale
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        check("t5 stale proto_err", bus.proto_err, 1'b1);
        check("t5 stale frame_cnt", bus.frame_cnt, 8'd1);
        tick();
        bus.fft_done = 1'b1;
        tick();
        bus.fft_done = 1'b0;
        check("t5 real done", bus.frame_cnt, 8'd2);
        check("t5 bank hold", bus.fft_bank, 1'b1);

        // Full run of NF frames with a 5-cycle engine, then ignored samples.
        do_reset();
        bus.fft_ready = 1'b1;
        busy = 0; n_wr = 0; n_start = 0; n_done = 0;
        for (int c = 0; c < 400 && !bus.all_done; c++) begin
            bus.fir_valid = (c < NF * FL);
            bus.fir_d     = DW'(c);
            bus.fft_done  = (busy == 1);
            done_now      = bus.fft_done;
            tick();
            if (bus.wr_en) n_wr++;
            if (bus.fft_start) n_start++;
            if (busy > 0) busy--;
            if (bus.fft_start) busy = 5;
            if (done_now) begin
                n_done++;
                check($sformatf("t3 frame_cnt%0d", n_done), bus.frame_cnt, CW'(n_done));
                check($sformatf("t3 all_done%0d", n_done), bus.all_done, n_done >= NF);
            end
        end
        bus.fft_done = 1'b0;
        bus.fir_valid = 1'b0;
        check("t3 all_done reached", bus.all_done, 1'b1);
        check("t3 writes", n_wr, NF * FL);
        n_extra = 0;
        for (int k = 0; k < FL; k++) begin
            send(DW'(k));
            if (bus.wr_en) n_extra++;
            if (bus.fft_start) n_start++;
        end
        repeat (4) begin
            tick();
            if (bus.fft_start) n_start++;
        end
        check("t3 extra writes", n_extra, 0);
        check("t3 starts", n_start, NF);
        check("t3 drop_cnt", bus.drop_cnt, 8'd0);
        check("t3 overflow", bus.overflow, 1'b0);
        check("t3 final frames", bus.frame_cnt, CW'(NF));
        check("t3 proto_err", bus.proto_err, 1'b0);

        // Asynchronous reset mid-frame with bank 0 busy and bank 1 at fill 7.
        do_reset();
        bus.fft_ready = 1'b1;
        for (int k = 0; k < FL + 7; k++) send(DW'(16'h0F00 + k));
        check_wr("t6 pre", 1'b1, 4'd6);
        #2;
        rst = 1'b1;
        #1;
        check_zero("t6 async reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        send(16'h7777);
        check_wr("t6 restart", 1'b0, 4'd0);
        check("t6 wr_data", bus.wr_data, 16'h7777);
        repeat (3) tick();
        check("t6 no stale start", bus.fft_start, 1'b0);
        check("t6 frame_cnt", bus.frame_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
